// File: rtl/code_lock_pkg.sv
// Shared key codes, lock FSM states and timer sizing for the keypad code lock.
package code_lock_pkg;

  localparam logic [3:0] KEY_ENTER = 4'hF;
  localparam logic [3:0] KEY_CLEAR = 4'hE;

  typedef enum logic [2:0] {
    ST_LOCKED,
    ST_ENTRY,
    ST_OPEN,
    ST_SET_NEW,
    ST_LOCKOUT
  } lock_state_t;

  function automatic int timer_width(input int max);
    return $clog2(max + 1);
  endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Registers, decodes and debounces the 4x4 keypad; one key_valid strobe per press,
// DEBOUNCE+2 cycles after a stable pattern appears. No backpressure: strobes are fire-and-forget.
module keypad_debounce
  import code_lock_pkg::*;
#(
  parameter int DEBOUNCE = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] conv8,
  output logic       key_valid,
  output logic [3:0] key_code
);

  localparam int CW = timer_width(DEBOUNCE);
  localparam logic [1:0] K_IDLE = 2'd0;
  localparam logic [1:0] K_KEY  = 2'd1;
  localparam logic [1:0] K_BAD  = 2'd2;

  logic [7:0]    conv_q;
  logic [1:0]    kind;
  logic [3:0]    code;
  logic [5:0]    tag;
  logic [5:0]    cand_q;
  logic [CW-1:0] cnt_q;
  logic          armed_q;
  logic          stable;

  // Exact-match decode: multi-hot, bit7 or a missing row/column all fall to K_BAD.
  always_comb begin
    kind = K_KEY;
    code = 4'h0;
    case (conv_q)
      8'h00: kind = K_IDLE;
      8'h41: code = 4'h1;
      8'h21: code = 4'h2;
      8'h11: code = 4'h3;
      8'h42: code = 4'h4;
      8'h22: code = 4'h5;
      8'h12: code = 4'h6;
      8'h44: code = 4'h7;
      8'h24: code = 4'h8;
      8'h14: code = 4'h9;
      8'h48: code = KEY_ENTER;
      8'h28: code = 4'h0;
      8'h18: code = KEY_CLEAR;
      default: kind = K_BAD;
    endcase
  end

  assign tag    = {kind, code};
  assign stable = (tag == cand_q) && (cnt_q == CW'(DEBOUNCE));

  always_ff @(posedge clock) begin
    if (!reset) begin
      conv_q    <= 8'h00;
      cand_q    <= {K_IDLE, 4'h0};
      cnt_q     <= '0;
      armed_q   <= 1'b1;
      key_valid <= 1'b0;
      key_code  <= 4'h0;
    end else begin
      conv_q    <= conv8;
      key_valid <= 1'b0;
      if (tag != cand_q) begin
        cand_q <= tag;
        cnt_q  <= CW'(1);
      end else if (cnt_q != CW'(DEBOUNCE)) begin
        cnt_q <= cnt_q + CW'(1);
      end
      // A debounced release re-arms; a debounced press fires once and disarms.
      if (stable) begin
        if (kind == K_IDLE) begin
          armed_q <= 1'b1;
        end else if (kind == K_KEY && armed_q) begin
          key_valid <= 1'b1;
          key_code  <= code;
          armed_q   <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/code_lock_ctrl.sv
// Keypad code lock: debounced entry, compare, lockout, auto-relock and code change.
// FSM acts on the key_valid cycle, status changes one edge later; no backpressure.
module code_lock_ctrl
  import code_lock_pkg::*;
#(
  parameter int                   DIGITS         = 4,
  parameter logic [4*DIGITS-1:0]  DEFAULT_CODE   = 16'h2433,
  parameter int                   MAX_WRONG      = 3,
  parameter int                   DEBOUNCE       = 16,
  parameter int                   TIMEOUT        = 100000,
  parameter int                   OPEN_CYCLES    = 50000,
  parameter int                   LOCKOUT_CYCLES = 200000
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [7:0]          conv8,
  input  logic                set_1,
  output logic                open,
  output logic                locked,
  output logic                alarm,
  output logic                set_mode,
  output logic                change,
  output logic [4*DIGITS-1:0] data,
  output logic [3:0]          count_wrong,
  output logic                key_valid,
  output logic [3:0]          key_code
);

  localparam int W     = 4 * DIGITS;
  localparam int TMAX0 = (TIMEOUT > OPEN_CYCLES) ? TIMEOUT : OPEN_CYCLES;
  localparam int TMAX  = (TMAX0 > LOCKOUT_CYCLES) ? TMAX0 : LOCKOUT_CYCLES;
  localparam int TW    = timer_width(TMAX);
  localparam int NW    = timer_width(DIGITS);

  localparam logic [TW-1:0] T_IDLE_LAST = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] T_OPEN_LAST = TW'(OPEN_CYCLES - 1);
  localparam logic [TW-1:0] T_LOCK_LAST = TW'(LOCKOUT_CYCLES - 1);

  lock_state_t   state_q, state_d;
  logic [W-1:0]  data_q, data_d, code_q, code_d, data_shift;
  logic [NW-1:0] cnt_q, cnt_d;
  logic [3:0]    wrong_q, wrong_d, wrong_inc;
  logic [TW-1:0] timer_q, timer_d;
  logic          change_d;
  logic          is_digit, is_enter, is_clear, full;

  keypad_debounce #(.DEBOUNCE(DEBOUNCE)) u_keypad (
    .clock     (clock),
    .reset     (reset),
    .conv8     (conv8),
    .key_valid (key_valid),
    .key_code  (key_code)
  );

  assign is_digit  = key_valid && (key_code <= 4'd9);
  assign is_enter  = key_valid && (key_code == KEY_ENTER);
  assign is_clear  = key_valid && (key_code == KEY_CLEAR);
  assign full      = (cnt_q == NW'(DIGITS));
  assign wrong_inc = (wrong_q == 4'hF) ? wrong_q : wrong_q + 4'd1;

  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    code_d     = code_q;
    cnt_d      = cnt_q;
    wrong_d    = wrong_q;
    change_d   = 1'b0;
    timer_d    = (state_q == ST_LOCKED) ? '0 : timer_q + TW'(1);
    data_shift = data_q << 4;
    data_shift[3:0] = key_code;

    case (state_q)
      ST_LOCKED: begin
        if (is_digit) begin
          data_d  = data_shift;
          cnt_d   = NW'(1);
          state_d = ST_ENTRY;
        end
      end
      ST_ENTRY, ST_SET_NEW: begin
        if (key_valid) timer_d = '0;
        if (is_digit) begin
          if (cnt_q < NW'(DIGITS)) begin
            data_d = data_shift;
            cnt_d  = cnt_q + NW'(1);
          end
        end else if (is_clear || (!key_valid && timer_q == T_IDLE_LAST)) begin
          data_d  = '0;
          cnt_d   = '0;
          state_d = ST_LOCKED;
        end else if (is_enter) begin
          data_d  = '0;
          cnt_d   = '0;
          state_d = ST_LOCKED;
          if (state_q == ST_SET_NEW) begin
            if (full) begin
              code_d   = data_q;
              change_d = 1'b1;
            end
          end else if (full && data_q == code_q) begin
            state_d = ST_OPEN;
            wrong_d = '0;
          end else begin
            wrong_d = wrong_inc;
            if (wrong_inc >= 4'(MAX_WRONG)) state_d = ST_LOCKOUT;
          end
        end
      end
      ST_OPEN: begin
        // set_1 takes priority over a same-cycle relock.
        if (set_1) begin
          data_d  = '0;
          cnt_d   = '0;
          state_d = ST_SET_NEW;
        end else if (is_clear || timer_q == T_OPEN_LAST) begin
          state_d = ST_LOCKED;
        end
      end
      ST_LOCKOUT: begin
        if (timer_q == T_LOCK_LAST) begin
          wrong_d = '0;
          state_d = ST_LOCKED;
        end
      end
      default: state_d = ST_LOCKED;
    endcase

    if (state_d != state_q) timer_d = '0;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= ST_LOCKED;
      data_q  <= '0;
      code_q  <= DEFAULT_CODE;
      cnt_q   <= '0;
      wrong_q <= '0;
      timer_q <= '0;
      change  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      code_q  <= code_d;
      cnt_q   <= cnt_d;
      wrong_q <= wrong_d;
      timer_q <= timer_d;
      change  <= change_d;
    end
  end

  assign locked      = (state_q == ST_LOCKED);
  assign open        = (state_q == ST_OPEN);
  assign alarm       = (state_q == ST_LOCKOUT);
  assign set_mode    = (state_q == ST_SET_NEW);
  assign data        = data_q;
  assign count_wrong = wrong_q;

endmodule

// File: doc/code_lock_ctrl.md
# code_lock_ctrl

Parametrised keypad code-lock controller: takes the raw 4x4 row/column keypad vector `conv8`, debounces and decodes it, and runs the lock state machine. The state machine handles N-digit code entry, compare, wrong-attempt counting with lockout, auto-relock and in-field code change. It replaces the fixed 4-digit lock core in the lock top level. The 7-segment driver consumes `data` unchanged.

## Interface
Parameters:
- `DIGITS`, 4: code length in BCD digits (1..8).
- `DEFAULT_CODE`, 16'h2433: BCD code loaded at reset; width 4*DIGITS.
- `MAX_WRONG`, 3: wrong attempts that trigger lockout (1..15).
- `DEBOUNCE`, 16: stable cycles needed for press and for release.
- `TIMEOUT`, 100000: idle cycles that abort an entry.
- `OPEN_CYCLES`, 50000: open duration before auto-relock.
- `LOCKOUT_CYCLES`, 200000: alarm duration.

Ports:
- `clock`, in, 1: single clock, rising edge.
- `reset`, in, 1: synchronous, active-low.
- `conv8`, in, 8: [7:4] column one-hot (bit6=col1, bit5=col2, bit4=col3, bit7 unused); [3:0] row one-hot (bit0=row1 .. bit3=row4).
- `set_1`, in, 1: request code change while open.
- `open`, out, 1: lock released.
- `locked`, out, 1: idle locked.
- `alarm`, out, 1: lockout active.
- `set_mode`, out, 1: new-code entry active.
- `change`, out, 1: one-cycle pulse when a new code is stored.
- `data`, out, 4*DIGITS: entered digits, BCD; the most recent digit is in [3:0].
- `count_wrong`, out, 4: consecutive wrong attempts.
- `key_valid`, out, 1: one-cycle accepted-key strobe.
- `key_code`, out, 4: code of the accepted key.

## Operation
- Key decode, rows 1-3: col1/col2/col3 map to 1/2/3, 4/5/6, 7/8/9.
- Key decode, row 4: col1 = `#` (ENTER, code 4'hF), col2 = 0, col3 = `*` (CLEAR, code 4'hE).
- Any multi-hot pattern, bit7 set, or missing row/column is invalid and treated as "no key".
- A press is accepted only after a valid pattern has been stable for `DEBOUNCE` cycles, and only if a release (`conv8`==0 for `DEBOUNCE` cycles) followed the previous accept. A held key yields exactly one strobe.
- FSM states:
  - LOCKED: `locked`=1. A digit shifts into `data`, entry count becomes 1, go to ENTRY. `#` and `*` are ignored.
  - ENTRY: a digit shifts in (`data` <= {data, digit}) while count < `DIGITS`; extra digits are dropped. `*` clears and goes to LOCKED.
  - ENTRY on `#`: count==`DIGITS` and `data`==code goes to OPEN and clears `count_wrong`. Otherwise `count_wrong`+1; if it reaches `MAX_WRONG`, go to LOCKOUT, else LOCKED. The buffer is cleared in every case.
  - ENTRY timeout: `TIMEOUT` idle cycles clear the buffer and return to LOCKED; `count_wrong` is unchanged.
  - OPEN: `open`=1. `set_1`==1 goes to SET_NEW with the buffer cleared. `*` goes to LOCKED. `OPEN_CYCLES` expiry goes to LOCKED. `set_1` wins over a same-cycle expiry.
  - SET_NEW: `set_mode`=1 and digits shift in as in ENTRY. `#` with count==`DIGITS` stores `data` as code, pulses `change` and goes to LOCKED. `#` with a short count, `*`, or timeout goes to LOCKED with the code unchanged and `count_wrong` untouched.
  - LOCKOUT: `alarm`=1 and all keys are ignored. After `LOCKOUT_CYCLES`, go to LOCKED with `count_wrong` cleared.
- Reset (`reset`=0 at an edge), including mid-operation: state LOCKED, code = `DEFAULT_CODE`, `data`=0, `count_wrong`=0, debouncer cleared.
- Outputs after reset: `locked`=1; `open`, `alarm`, `set_mode`, `change`, `key_valid`=0; `key_code`=0.

## Timing
- `conv8` is registered once before the debouncer.
- A pattern applied before edge N gives `key_valid`=1 in the cycle after edge N+`DEBOUNCE`+1.
- The FSM acts on that `key_valid` cycle. State and all status outputs change at the following edge.
- `change` is high for exactly that one cycle.
- Timers count in ENTRY, SET_NEW, OPEN and LOCKOUT only, and restart on every state entry. ENTRY and SET_NEW timers also restart on every `key_valid`.
- `count_wrong` saturates at 15 and never wraps.

## Structure
- Package `code_lock_pkg`: key-code constants (KEY_ENTER=4'hF, KEY_CLEAR=4'hE), FSM state enum, and the function `timer_width(max)` = $clog2(max+1).
- Sub-module `keypad_debounce`: `conv8` register, decode, press/release debounce. Outputs `key_valid`/`key_code`.
- Top level: FSM, digit shift register, stored code, wrong counter, shared timer.

## Test plan
All cases use `DEBOUNCE`=4 and the other parameters at their defaults.
- Reset, then keys 2,4,3,3,# (each held 100 cycles, released 10) -> `open`=1, `count_wrong`=0, `data`=0.
- Keys 2,4,3,1,# -> `locked`=1, `count_wrong`=1. Repeat twice -> `alarm`=1, `count_wrong`=3. After `LOCKOUT_CYCLES` -> `locked`=1, `count_wrong`=0.
- Key 2 held 500 cycles -> exactly one `key_valid`, `key_code`=2. Same key with 2-cycle release gaps -> no second strobe. Pattern 8'b0110_0001 -> no strobe.
- Open with 2433, raise `set_1`, enter 9,0,1,7,# -> `change` pulses once, `locked`=1. 9017# then opens; 2433# counts wrong.
- Entries 2,4,* and 2,4,3,3,3,#: first -> `data`=0, LOCKED. Second -> extra digit dropped, opens. `reset`=0 during the second entry -> code returns to 16'h2433, `data`=0.
- Open, idle `OPEN_CYCLES` -> `locked`=1 exactly `OPEN_CYCLES` cycles after entering OPEN.
